// File: rtl/mux8_2_arb_if.sv
// Handshake bundle for mux8_2_arb: two valid/ready byte producers and one output stage.
// The *_last signals exist only when MUX8_2_ARB_LOCK_EN is defined.
interface mux8_2_arb_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sel;
`ifdef MUX8_2_ARB_LOCK_EN
    logic             a_last;
    logic             b_last;

    modport master (
        output a_data, a_valid, a_last, b_data, b_valid, b_last, out_ready,
        input  a_ready, b_ready, out_data, out_valid, out_sel
    );
    modport slave (
        input  a_data, a_valid, a_last, b_data, b_valid, b_last, out_ready,
        output a_ready, b_ready, out_data, out_valid, out_sel
    );
`else
    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, out_data, out_valid, out_sel
    );
    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, out_data, out_valid, out_sel
    );
`endif
endinterface

// File: rtl/mux8_2_arb.sv
// Round-robin 2:1 arbiter feeding a single-entry output register.
// Optional packet grant locking is enabled with the MUX8_2_ARB_LOCK_EN macro.
module mux8_2_arb #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux8_2_arb_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_sel_r;
    logic             prio_a_r;
    logic             load_en_s;
    logic             grant_a_s;
    logic             grant_b_s;
    logic             acc_a_s;
    logic             acc_b_s;
    logic             last_a_s;
    logic             last_b_s;
`ifdef MUX8_2_ARB_LOCK_EN
    logic             locked_r;
    logic             owner_a_r;
`endif

    // Load enable, grant selection and end-of-packet decode.
    always_comb begin
        load_en_s = 1'b0;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        last_a_s  = 1'b1;
        last_b_s  = 1'b1;
        if (rst) begin
            load_en_s = 1'b0;
        end else if ((state_r == EMPTY) || bus.out_ready) begin
            load_en_s = 1'b1;
        end else begin
            load_en_s = 1'b0;
        end
`ifdef MUX8_2_ARB_LOCK_EN
        last_a_s = bus.a_last;
        last_b_s = bus.b_last;
        // A locked grant belongs to the owner even when the owner is idle.
        if (locked_r) begin
            grant_a_s = bus.a_valid && owner_a_r;
            grant_b_s = bus.b_valid && !owner_a_r;
        end else begin
            grant_a_s = bus.a_valid && (!bus.b_valid || prio_a_r);
            grant_b_s = bus.b_valid && !grant_a_s;
        end
`else
        grant_a_s = bus.a_valid && (!bus.b_valid || prio_a_r);
        grant_b_s = bus.b_valid && !grant_a_s;
`endif
    end

    assign bus.a_ready   = load_en_s && grant_a_s;
    assign bus.b_ready   = load_en_s && grant_b_s;
    assign acc_a_s       = bus.a_valid && bus.a_ready;
    assign acc_b_s       = bus.b_valid && bus.b_ready;
    assign bus.out_valid = (state_r == FULL);
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;

    // Occupancy FSM, output register and arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= EMPTY;
            out_data_r <= {WIDTH{1'b0}};
            out_sel_r  <= 1'b0;
            prio_a_r   <= 1'b1;
`ifdef MUX8_2_ARB_LOCK_EN
            locked_r   <= 1'b0;
            owner_a_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                EMPTY: begin
                    if (acc_a_s || acc_b_s) begin
                        state_r <= FULL;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    if (acc_a_s || acc_b_s) begin
                        state_r <= FULL;
                    end else if (bus.out_ready) begin
                        state_r <= EMPTY;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase

            if (acc_a_s) begin
                out_data_r <= bus.a_data;
                out_sel_r  <= 1'b1;
                if (last_a_s) begin
                    prio_a_r <= 1'b0;
                end else begin
                    prio_a_r <= prio_a_r;
                end
`ifdef MUX8_2_ARB_LOCK_EN
                locked_r  <= !last_a_s;
                owner_a_r <= 1'b1;
`endif
            end else if (acc_b_s) begin
                out_data_r <= bus.b_data;
                out_sel_r  <= 1'b0;
                if (last_b_s) begin
                    prio_a_r <= 1'b1;
                end else begin
                    prio_a_r <= prio_a_r;
                end
`ifdef MUX8_2_ARB_LOCK_EN
                locked_r  <= !last_b_s;
                owner_a_r <= 1'b0;
`endif
            end else begin
                out_data_r <= out_data_r;
                out_sel_r  <= out_sel_r;
                prio_a_r   <= prio_a_r;
            end
        end
    end

endmodule
